// File: rtl/ldpc_pin_port_sequencer_if.sv
// Host request/response channel plus the core's bit-serial pin port.
// The slave modport is the sequencer side, the master modport the host/core side.
interface ldpc_pin_port_sequencer_if #(
   parameter int SEL_W  = 16,
   parameter int WORD_W = 32,
   parameter int LEN_W  = 6
);
   logic              req_valid_i;
   logic              req_ready_o;
   logic              req_write_i;
   logic [SEL_W-1:0]  req_addr_i;
   logic [LEN_W-1:0]  req_len_i;
   logic [WORD_W-1:0] req_wdata_i;
   logic              abort_i;
   logic              rsp_valid_o;
   logic              rsp_ready_i;
   logic [WORD_W-1:0] rsp_rdata_o;
   logic              rsp_err_o;
   logic              busy_o;
   logic [SEL_W-1:0]  P_in_out_sel_o;
   logic              P_inputnoutput_o;
   logic              P_input_o;
   logic              PO_output_i;

   modport slave (
      input  req_valid_i, req_write_i, req_addr_i, req_len_i, req_wdata_i,
      input  abort_i, rsp_ready_i, PO_output_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o,
      output P_in_out_sel_o, P_inputnoutput_o, P_input_o
   );

   modport master (
      output req_valid_i, req_write_i, req_addr_i, req_len_i, req_wdata_i,
      output abort_i, rsp_ready_i, PO_output_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o,
      input  P_in_out_sel_o, P_inputnoutput_o, P_input_o
   );
endinterface

// File: rtl/ldpc_pin_port_sequencer.sv
// Word-level sequencer for the ldpcEncDec bit-serial pin port: walks a select
// range one bit at a time, writing or sampling the core, then returns one response.
module ldpc_pin_port_sequencer #(
   parameter int SEL_W      = 16,
   parameter int WORD_W     = 32,
   parameter int LEN_W      = 6,
   parameter int SETTLE_CYC = 2
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_n_i,
   ldpc_pin_port_sequencer_if.slave bus
);
   localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int EXT_W = SEL_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ADDR  = 2'd1,
      ST_DRIVE = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t            state_r;
   logic              write_r;
   logic [SEL_W-1:0]  addr_r;
   logic [LEN_W-1:0]  len_r;
   logic [WORD_W-1:0] wdata_r;
   logic [IDX_W-1:0]  idx_r;
   logic [CNT_W-1:0]  cnt_r;

   logic              req_ready_r;
   logic              rsp_valid_r;
   logic [WORD_W-1:0] rdata_r;
   logic              err_r;
   logic              busy_r;
   logic [SEL_W-1:0]  sel_r;
   logic              inout_r;
   logic              pin_r;

   logic [EXT_W-1:0]  req_end_s;
   logic              req_bad_s;
   logic              last_bit_s;
   logic              last_cnt_s;
   logic [IDX_W-1:0]  idx_inc_s;

   // Last select touched is computed one bit wider so a range wrapping past the top is caught.
   assign req_end_s  = {1'b0, bus.req_addr_i} + EXT_W'(bus.req_len_i) - EXT_W'(1'b1);
   assign req_bad_s  = (bus.req_len_i == {LEN_W{1'b0}}) ||
                       (bus.req_len_i > LEN_W'(WORD_W)) ||
                       req_end_s[SEL_W];
   assign last_bit_s = (idx_r == IDX_W'(len_r - LEN_W'(1'b1)));
   assign last_cnt_s = (cnt_r == CNT_W'(SETTLE_CYC - 1));
   assign idx_inc_s  = idx_r + IDX_W'(1'b1);

   assign bus.req_ready_o      = req_ready_r;
   assign bus.rsp_valid_o      = rsp_valid_r;
   assign bus.rsp_rdata_o      = rdata_r;
   assign bus.rsp_err_o        = err_r;
   assign bus.busy_o           = busy_r;
   assign bus.P_in_out_sel_o   = sel_r;
   assign bus.P_inputnoutput_o = inout_r;
   assign bus.P_input_o        = pin_r;

   // Sequencer FSM; every output is a register set on entry to the state that owns it.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         state_r     <= ST_IDLE;
         write_r     <= 1'b0;
         addr_r      <= {SEL_W{1'b0}};
         len_r       <= {LEN_W{1'b0}};
         wdata_r     <= {WORD_W{1'b0}};
         idx_r       <= {IDX_W{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         req_ready_r <= 1'b1;
         rsp_valid_r <= 1'b0;
         rdata_r     <= {WORD_W{1'b0}};
         err_r       <= 1'b0;
         busy_r      <= 1'b0;
         sel_r       <= {SEL_W{1'b0}};
         inout_r     <= 1'b0;
         pin_r       <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.req_valid_i && req_ready_r) begin
                  write_r     <= bus.req_write_i;
                  addr_r      <= bus.req_addr_i;
                  len_r       <= bus.req_len_i;
                  wdata_r     <= bus.req_wdata_i;
                  idx_r       <= {IDX_W{1'b0}};
                  cnt_r       <= {CNT_W{1'b0}};
                  rdata_r     <= {WORD_W{1'b0}};
                  req_ready_r <= 1'b0;
                  busy_r      <= 1'b1;
                  if (req_bad_s) begin
                     state_r     <= ST_RESP;
                     rsp_valid_r <= 1'b1;
                     err_r       <= 1'b1;
                  end else begin
                     // Select for bit 0 is presented while the strobe is still low.
                     state_r <= ST_ADDR;
                     sel_r   <= bus.req_addr_i;
                     pin_r   <= bus.req_wdata_i[0];
                     inout_r <= 1'b0;
                  end
               end
            end
            ST_ADDR: begin
               if (bus.abort_i) begin
                  state_r     <= ST_RESP;
                  rsp_valid_r <= 1'b1;
                  err_r       <= 1'b1;
                  sel_r       <= {SEL_W{1'b0}};
                  pin_r       <= 1'b0;
                  inout_r     <= 1'b0;
               end else begin
                  state_r <= ST_DRIVE;
                  cnt_r   <= {CNT_W{1'b0}};
                  inout_r <= write_r;
               end
            end
            ST_DRIVE: begin
               if (last_cnt_s && !write_r) begin
                  rdata_r[idx_r] <= bus.PO_output_i;
               end
               if (bus.abort_i || (last_cnt_s && last_bit_s)) begin
                  state_r     <= ST_RESP;
                  rsp_valid_r <= 1'b1;
                  err_r       <= bus.abort_i;
                  sel_r       <= {SEL_W{1'b0}};
                  pin_r       <= 1'b0;
                  inout_r     <= 1'b0;
               end else if (last_cnt_s) begin
                  state_r <= ST_ADDR;
                  idx_r   <= idx_inc_s;
                  sel_r   <= addr_r + SEL_W'(idx_inc_s);
                  pin_r   <= wdata_r[idx_inc_s];
                  inout_r <= 1'b0;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1'b1);
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready_i) begin
                  state_r     <= ST_IDLE;
                  rsp_valid_r <= 1'b0;
                  rdata_r     <= {WORD_W{1'b0}};
                  err_r       <= 1'b0;
                  req_ready_r <= 1'b1;
                  busy_r      <= 1'b0;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               req_ready_r <= 1'b1;
               rsp_valid_r <= 1'b0;
               rdata_r     <= {WORD_W{1'b0}};
               err_r       <= 1'b0;
               busy_r      <= 1'b0;
               sel_r       <= {SEL_W{1'b0}};
               inout_r     <= 1'b0;
               pin_r       <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ldpc_pin_port_sequencer.sv
// Randomized scoreboard bench: requests push expected responses and pin traces,
// an independent monitor checks responses, latency and strobe behaviour.
module tb_ldpc_pin_port_sequencer;
   localparam int SEL_W  = 16;
   localparam int WORD_W = 32;
   localparam int LEN_W  = 6;
   localparam int SETTLE = 2;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          acc;
      int          stall;
   } exp_t;

   typedef struct {
      logic [15:0] sel;
      logic        b;
   } pin_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   exp_t sb_q[$];
   pin_t pin_q[$];
   bit   ref_mem [0:65535];
   bit   wr_valid [0:65535];
   bit   wr_val [0:65535];

   ldpc_pin_port_sequencer_if #(.SEL_W(SEL_W), .WORD_W(WORD_W), .LEN_W(LEN_W)) bus ();

   ldpc_pin_port_sequencer #(.SEL_W(SEL_W), .WORD_W(WORD_W), .LEN_W(LEN_W), .SETTLE_CYC(SETTLE)) dut (
      .wb_clk_i   (clk),
      .wb_rst_n_i (rst_n),
      .bus        (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic bit hash_bit(input logic [15:0] a);
      logic [15:0] t;
      t = a ^ (a >> 3) ^ 16'h6C35;
      return t[0] ^ t[5] ^ t[11];
   endfunction

   // Core model: latches P_input on every edge the strobe is high, otherwise returns seeded content.
   always @(posedge clk) begin
      if (bus.P_inputnoutput_o) begin
         wr_valid[bus.P_in_out_sel_o] <= 1'b1;
         wr_val[bus.P_in_out_sel_o]   <= bus.P_input_o;
      end
   end
   assign bus.PO_output_i = wr_valid[bus.P_in_out_sel_o] ? wr_val[bus.P_in_out_sel_o]
                                                         : hash_bit(bus.P_in_out_sel_o);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_reset_values();
      chk("rst_req_ready", 64'(bus.req_ready_o), 64'(1));
      chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
      chk("rst_rdata", 64'(bus.rsp_rdata_o), 64'(0));
      chk("rst_err", 64'(bus.rsp_err_o), 64'(0));
      chk("rst_busy", 64'(bus.busy_o), 64'(0));
      chk("rst_pins", 64'({bus.P_in_out_sel_o, bus.P_inputnoutput_o, bus.P_input_o}), 64'(0));
   endtask

   // Issue one request; the expected response comes from the bit-range rules applied to ref_mem.
   task automatic do_req(input bit wr, input int addr, input int len, input logic [31:0] wd,
                         input int abort_o, input int stall, input bit expect_rsp);
      exp_t e;
      int   t;
      int   nb;
      bit   legal;
      pin_t p;
      legal = (len >= 1) && (len <= WORD_W) && (addr + len - 1 <= 65535);
      t = 0;
      @(negedge clk);
      while (!bus.req_ready_o && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!bus.req_ready_o) begin
         chk("req_ready_timeout", 64'(bus.req_ready_o), 64'(1));
         return;
      end
      bus.req_valid_i = 1'b1;
      bus.req_write_i = wr;
      bus.req_addr_i  = 16'(addr);
      bus.req_len_i   = LEN_W'(len);
      bus.req_wdata_i = wd;
      e.rdata = 32'h0;
      e.err   = !legal;
      e.acc   = cyc;
      e.stall = stall;
      nb = len;
      if (legal && !wr && abort_o > 0) begin
         nb = (((abort_o - 1) % 3) == 2) ? ((abort_o - 1) / 3 + 1) : ((abort_o - 1) / 3);
         e.err = 1'b1;
         e.lat = abort_o + 1;
      end else begin
         e.lat = legal ? (len * (1 + SETTLE) + 1) : 1;
      end
      if (legal && !wr) begin
         for (int i = 0; i < nb; i++) e.rdata[i] = ref_mem[addr + i];
      end
      if (legal && wr) begin
         for (int i = 0; i < len; i++) begin
            p.sel = 16'(addr + i);
            p.b   = wd[i];
            pin_q.push_back(p);
            if (expect_rsp) ref_mem[addr + i] = wd[i];
         end
      end
      if (expect_rsp) sb_q.push_back(e);
      @(posedge clk);
      #1;
      bus.req_valid_i = 1'b0;
      bus.req_write_i = 1'($urandom);
      bus.req_addr_i  = 16'($urandom);
      bus.req_len_i   = LEN_W'($urandom);
      bus.req_wdata_i = $urandom;
      if (legal && !wr && abort_o > 0) begin
         @(negedge clk);
         while (cyc < e.acc + abort_o) @(negedge clk);
         bus.abort_i = 1'b1;
         @(negedge clk);
         bus.abort_i = 1'b0;
      end
   endtask

   // Monitor: response scoreboard, handshake pacing and strobe/select discipline.
   initial begin
      bit          in_rsp;
      bit          gave;
      bit          prev_io;
      int          wcnt;
      int          run;
      exp_t        cur;
      pin_t        p;
      logic [31:0] hr;
      logic        he;
      logic [15:0] prev_sel;
      logic        prev_pin;
      in_rsp = 0; gave = 0; prev_io = 0; wcnt = 0; run = 0;
      prev_sel = 16'h0; prev_pin = 1'b0; hr = 32'h0; he = 1'b0;
      cur.stall = 0; cur.lat = -1; cur.acc = 0; cur.rdata = 32'h0; cur.err = 1'b0;
      bus.rsp_ready_i = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_rsp = 0; gave = 0; prev_io = 0; run = 0;
            bus.rsp_ready_i = 1'b0;
         end else begin
            if (bus.P_inputnoutput_o) begin
               if (!prev_io) begin
                  chk("sel_set_before_strobe", 64'(bus.P_in_out_sel_o), 64'(prev_sel));
                  if (pin_q.size() == 0) begin
                     chk("unexpected_strobe", 64'(bus.P_inputnoutput_o), 64'(0));
                  end else begin
                     p = pin_q.pop_front();
                     chk("drive_sel", 64'(bus.P_in_out_sel_o), 64'(p.sel));
                     chk("drive_bit", 64'(bus.P_input_o), 64'(p.b));
                  end
                  run = 1;
               end else begin
                  chk("pins_held_while_strobe", 64'({bus.P_in_out_sel_o, bus.P_input_o}),
                      64'({prev_sel, prev_pin}));
                  run++;
               end
            end else if (prev_io) begin
               chk("strobe_length", 64'(run), 64'(SETTLE));
            end
            prev_io  = bus.P_inputnoutput_o;
            prev_sel = bus.P_in_out_sel_o;
            prev_pin = bus.P_input_o;

            if (bus.rsp_valid_o) begin
               if (!in_rsp) begin
                  in_rsp = 1; wcnt = 0; gave = 0;
                  if (sb_q.size() == 0) begin
                     chk("unexpected_rsp", 64'(bus.rsp_valid_o), 64'(0));
                     cur.stall = 0; cur.lat = -1;
                  end else begin
                     cur = sb_q.pop_front();
                     chk("rsp_rdata", 64'(bus.rsp_rdata_o), 64'(cur.rdata));
                     chk("rsp_err", 64'(bus.rsp_err_o), 64'(cur.err));
                     chk("rsp_latency", 64'(cyc - cur.acc), 64'(cur.lat));
                     chk("all_bits_strobed", 64'(pin_q.size()), 64'(0));
                  end
                  hr = bus.rsp_rdata_o;
                  he = bus.rsp_err_o;
               end else begin
                  if (gave) chk("rsp_drop_after_hs", 64'(bus.rsp_valid_o), 64'(0));
                  chk("rsp_stable", 64'({bus.rsp_rdata_o, bus.rsp_err_o}), 64'({hr, he}));
               end
               chk("resp_ready_low", 64'(bus.req_ready_o), 64'(0));
               chk("resp_busy", 64'(bus.busy_o), 64'(1));
               chk("resp_pins_idle", 64'({bus.P_in_out_sel_o, bus.P_inputnoutput_o, bus.P_input_o}), 64'(0));
               if (wcnt >= cur.stall) begin
                  bus.rsp_ready_i = 1'b1;
                  gave = 1;
               end else begin
                  bus.rsp_ready_i = 1'b0;
               end
               wcnt++;
            end else begin
               if (in_rsp) begin
                  chk("idle_after_hs", 64'({bus.req_ready_o, bus.busy_o}), 64'(2'b10));
               end
               in_rsp = 0; gave = 0;
               bus.rsp_ready_i = 1'b0;
            end
         end
      end
   end

   // Stimulus: directed corner cases, reset during a write, then randomized traffic.
   initial begin
      int t;
      int len;
      int addr;
      int ab;
      bit wr;
      for (int i = 0; i < 65536; i++) ref_mem[i] = hash_bit(16'(i));
      bus.req_valid_i = 1'b0; bus.req_write_i = 1'b0; bus.req_addr_i = 16'h0;
      bus.req_len_i = 6'd0; bus.req_wdata_i = 32'h0; bus.abort_i = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values();
      @(posedge clk); #1 rst_n = 1'b1;

      do_req(1, 'h0010, 4, 32'hA, 0, 0, 1);
      do_req(1, 'h0100, 8, 32'hC3, 0, 1, 1);
      do_req(0, 'h0100, 8, 32'hFFFF_FFFF, 0, 0, 1);
      do_req(0, 'h0200, 0, 32'h0, 0, 0, 1);
      do_req(0, 'h0200, 33, 32'h0, 0, 0, 1);
      do_req(1, 'hFFFE, 4, 32'hF, 0, 0, 1);
      do_req(0, 'hFFE1, 32, 32'h0, 0, 0, 1);
      do_req(0, 'hFFE0, 32, 32'h0, 0, 0, 1);
      do_req(0, 'hFFFF, 1, 32'h0, 0, 0, 1);
      do_req(1, 'h0300, 16, 32'h0000_FFFF, 0, 0, 1);
      do_req(0, 'h0300, 16, 32'h0, 16, 0, 1);
      do_req(0, 'h0300, 4, 32'h0, 12, 0, 1);

      bus.abort_i = 1'b1;
      repeat (2) @(negedge clk);
      bus.abort_i = 1'b0;
      do_req(0, 'h0010, 4, 32'h0, 0, 10, 1);
      t = 0;
      while (!bus.rsp_valid_o && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("stall_rsp_seen", 64'(bus.rsp_valid_o), 64'(1));
      bus.abort_i = 1'b1;
      repeat (2) @(negedge clk);
      bus.abort_i = 1'b0;

      do_req(1, 'h8000, 8, $urandom, 0, 0, 0);
      repeat (5) @(negedge clk);
      chk("strobe_before_reset", 64'(bus.P_inputnoutput_o), 64'(1));
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_values();
      sb_q.delete();
      pin_q.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("no_rsp_after_reset", 64'(bus.rsp_valid_o), 64'(0));
      end
      do_req(1, 'h0400, 5, 32'h15, 0, 0, 1);
      do_req(0, 'h0400, 5, 32'h0, 0, 0, 1);

      for (int n = 0; n < 40; n++) begin
         wr   = 1'($urandom_range(0, 1));
         len  = $urandom_range(1, 32);
         addr = $urandom_range(0, 'h7FE0);
         if (n % 10 == 9) len = (n % 20 == 9) ? 0 : 33;
         ab = (!wr && len >= 1 && len <= 32 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 3 * len) : 0;
         do_req(wr, addr, len, $urandom, ab, $urandom_range(0, 2), 1);
      end

      t = 0;
      while ((sb_q.size() != 0 || bus.busy_o) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk("scoreboard_drained", 64'(sb_q.size()), 64'(0));
      chk("pin_trace_drained", 64'(pin_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
